exe_muldiv_stage: RTL and testbench

EXE_MULDIV_STAGE -- requirements
Module: exe_muldiv_stage

---
 rtl/exe_muldiv_stage_pkg.sv | 33 +++
 rtl/exe_muldiv_stage_if.sv | 34 +++
 rtl/exe_muldiv_stage_div_iter.sv | 80 ++++++++
 rtl/exe_muldiv_stage.sv | 117 +++++++++++
 tb/tb_exe_muldiv_stage.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/exe_muldiv_stage_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit:
// op encodings, divider sequencing states and op-class helpers.
package exe_muldiv_stage_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_RUN  = 2'd1,
        DS_FIX  = 2'd2,
        DS_DONE = 2'd3
    } div_state_e;

    function automatic logic op_is_mul(input op_e op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

    function automatic logic op_is_div(input op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/exe_muldiv_stage_if.sv
// Upstream/downstream handshake and result bus of the muldiv execute stage.
interface exe_muldiv_stage_if import exe_muldiv_stage_pkg::*; #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic              flush_in;
    logic              id_valid_in;
    logic              exe_allowin_out;
    logic              mem_allowin_in;
    logic              exe_valid_out;
    logic [OP_W-1:0]   id_op_in;
    logic [XLEN-1:0]   id_src0_in;
    logic [XLEN-1:0]   id_src1_in;
    logic [TAG_W-1:0]  id_tag_in;
    logic [TAG_W-1:0]  exe_tag_out;
    logic [XLEN-1:0]   exe_hi_out;
    logic [XLEN-1:0]   exe_lo_out;
    logic              exe_busy_out;
    logic              exe_divzero_out;

    modport master (
        output flush_in, id_valid_in, mem_allowin_in, id_op_in,
               id_src0_in, id_src1_in, id_tag_in,
        input  exe_allowin_out, exe_valid_out, exe_tag_out, exe_hi_out,
               exe_lo_out, exe_busy_out, exe_divzero_out
    );

    modport slave (
        input  flush_in, id_valid_in, mem_allowin_in, id_op_in,
               id_src0_in, id_src1_in, id_tag_in,
        output exe_allowin_out, exe_valid_out, exe_tag_out, exe_hi_out,
               exe_lo_out, exe_busy_out, exe_divzero_out
    );
endinterface

// File: rtl/exe_muldiv_stage_div_iter.sv
// Iterative restoring divider: XLEN quotient-bit cycles plus one sign-fixup
// cycle; result and done held until the next start or abort.
module div_iter import exe_muldiv_stage_pkg::*; #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_start,
    input  logic            i_abort,
    input  logic            i_signed,
    input  logic [XLEN-1:0] i_dividend,
    input  logic [XLEN-1:0] i_divisor,
    output logic            o_done,
    output logic [XLEN-1:0] o_quotient,
    output logic [XLEN-1:0] o_remainder,
    output logic            o_divzero
);
    localparam int CNT_W = $clog2(XLEN + 1);

    div_state_e       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [XLEN-1:0]  r_rem, r_quo, r_dvs;
    logic             r_neg_q, r_neg_r, r_dz;
    logic             w_a_neg, w_b_neg;
    logic [XLEN-1:0]  w_a_abs, w_b_abs;
    logic [XLEN:0]    w_rem_sh, w_diff;

    assign w_a_neg  = i_signed & i_dividend[XLEN-1];
    assign w_b_neg  = i_signed & i_divisor[XLEN-1];
    assign w_a_abs  = w_a_neg ? -i_dividend : i_dividend;
    assign w_b_abs  = w_b_neg ? -i_divisor  : i_divisor;
    // r_quo shifts dividend bits out of its top while quotient bits enter below
    assign w_rem_sh = {r_rem, r_quo[XLEN-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_dvs};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            DS_RUN:  if (r_cnt == CNT_W'(1)) w_state_nxt = DS_FIX;
            DS_FIX:  w_state_nxt = DS_DONE;
            default: ;
        endcase
        if (i_start) w_state_nxt = DS_RUN;
        if (i_abort) w_state_nxt = DS_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= DS_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (i_start && !i_abort)   r_cnt <= CNT_W'(XLEN);
            else if (r_state == DS_RUN) r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (i_start) begin
            r_rem   <= '0;
            r_quo   <= w_a_abs;
            r_dvs   <= w_b_abs;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_dz    <= (i_divisor == '0);
        end else if (r_state == DS_RUN) begin
            r_rem <= w_diff[XLEN] ? w_rem_sh[XLEN-1:0] : w_diff[XLEN-1:0];
            r_quo <= {r_quo[XLEN-2:0], ~w_diff[XLEN]};
        end else if (r_state == DS_FIX) begin
            // a zero divisor leaves the dividend in r_rem, so only LO needs forcing
            r_quo <= r_dz ? '1 : (r_neg_q ? -r_quo : r_quo);
            r_rem <= r_neg_r ? -r_rem : r_rem;
        end
    end

    assign o_done      = (r_state == DS_DONE);
    assign o_quotient  = r_quo;
    assign o_remainder = r_rem;
    assign o_divzero   = r_dz;
endmodule

// File: rtl/exe_muldiv_stage.sv
// Execute-stage multiply/divide unit with valid/allowin handshake owning the
// architectural HI/LO pair; multiplier is an inline register chain.
module exe_muldiv_stage import exe_muldiv_stage_pkg::*; #(
    parameter int XLEN    = 32,
    parameter int MUL_LAT = 2,
    parameter int TAG_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    exe_muldiv_stage_if.slave bus
);
    localparam int MCNT_W = $clog2(MUL_LAT + 1);

    op_e                      r_op;
    logic                     r_valid, r_mdone;
    logic [MCNT_W-1:0]        r_mcnt;
    logic [TAG_W-1:0]         r_tag;
    logic [XLEN-1:0]          r_src0, r_src1, r_hi, r_lo;
    logic [2*XLEN-1:0]        r_mul_p [MUL_LAT];
    op_e                      w_in_op;
    logic                     w_ready, w_allowin, w_capture, w_commit, w_mul_signed;
    logic signed [2*XLEN-1:0] w_mul_a, w_mul_b, w_mul_prod;
    logic                     w_div_done, w_div_dz;
    logic [XLEN-1:0]          w_div_quo, w_div_rem;

    assign w_in_op   = op_e'(bus.id_op_in);
    assign w_ready   = op_is_mul(r_op) ? r_mdone : (op_is_div(r_op) ? w_div_done : 1'b1);
    assign w_allowin = !r_valid || (w_ready && bus.mem_allowin_in);
    assign w_capture = w_allowin && bus.id_valid_in && !bus.flush_in;
    assign w_commit  = r_valid && w_ready && bus.mem_allowin_in && !bus.flush_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_mdone <= 1'b0;
            r_mcnt  <= '0;
            r_op    <= OP_NONE;
            r_tag   <= '0;
        end else if (bus.flush_in) begin
            r_valid <= 1'b0;
            r_mdone <= 1'b0;
            r_mcnt  <= '0;
        end else begin
            if (w_allowin) r_valid <= bus.id_valid_in;
            if (w_capture) begin
                r_op    <= w_in_op;
                r_tag   <= bus.id_tag_in;
                r_mdone <= 1'b0;
                r_mcnt  <= op_is_mul(w_in_op) ? MCNT_W'(MUL_LAT) : '0;
            end else if (r_mcnt != '0) begin
                r_mcnt <= r_mcnt - MCNT_W'(1);
                if (r_mcnt == MCNT_W'(1)) r_mdone <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_src0 <= bus.id_src0_in;
            r_src1 <= bus.id_src1_in;
        end
    end

    // Operands sit still until the next capture, so every chain stage settles on the product
    assign w_mul_signed = (r_op == OP_MULT);
    assign w_mul_a      = signed'({{XLEN{w_mul_signed & r_src0[XLEN-1]}}, r_src0});
    assign w_mul_b      = signed'({{XLEN{w_mul_signed & r_src1[XLEN-1]}}, r_src1});
    assign w_mul_prod   = w_mul_a * w_mul_b;

    always_ff @(posedge clk) begin
        r_mul_p[0] <= w_mul_prod;
        for (int k = 1; k < MUL_LAT; k++) r_mul_p[k] <= r_mul_p[k-1];
    end

    div_iter #(.XLEN(XLEN)) u_div (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (w_capture && op_is_div(w_in_op)),
        .i_abort     (bus.flush_in),
        .i_signed    (w_in_op == OP_DIV),
        .i_dividend  (bus.id_src0_in),
        .i_divisor   (bus.id_src1_in),
        .o_done      (w_div_done),
        .o_quotient  (w_div_quo),
        .o_remainder (w_div_rem),
        .o_divzero   (w_div_dz)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_commit) begin
            case (r_op)
                OP_MULT, OP_MULTU: begin
                    r_hi <= r_mul_p[MUL_LAT-1][2*XLEN-1:XLEN];
                    r_lo <= r_mul_p[MUL_LAT-1][XLEN-1:0];
                end
                OP_DIV, OP_DIVU: begin
                    r_hi <= w_div_rem;
                    r_lo <= w_div_quo;
                end
                OP_MTHI: r_hi <= r_src0;
                OP_MTLO: r_lo <= r_src0;
                default: ;
            endcase
        end
    end

    assign bus.exe_allowin_out = w_allowin;
    assign bus.exe_valid_out   = r_valid && w_ready;
    assign bus.exe_tag_out     = r_tag;
    assign bus.exe_hi_out      = r_hi;
    assign bus.exe_lo_out      = r_lo;
    assign bus.exe_busy_out    = r_valid && (op_is_mul(r_op) || op_is_div(r_op)) && !w_ready;
    assign bus.exe_divzero_out = r_valid && op_is_div(r_op) && w_div_done && w_div_dz;
endmodule

// File: tb/tb_exe_muldiv_stage.sv
// Directed bench for exe_muldiv_stage: multiply, divide, stall, flush,
// back-to-back and reset scenarios against hand-computed HI/LO values.
module tb_exe_muldiv_stage;
    localparam int XLEN    = 32;
    localparam int MUL_LAT = 2;
    localparam int TAG_W   = 5;

    localparam logic [2:0] T_NONE  = 3'd0;
    localparam logic [2:0] T_MULT  = 3'd1;
    localparam logic [2:0] T_MULTU = 3'd2;
    localparam logic [2:0] T_DIV   = 3'd3;
    localparam logic [2:0] T_DIVU  = 3'd4;
    localparam logic [2:0] T_MTHI  = 3'd5;
    localparam logic [2:0] T_MTLO  = 3'd6;
    localparam logic [2:0] T_RSVD  = 3'd7;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } div_vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc, busy_low, vcnt;
    div_vec_t dv [7];

    exe_muldiv_stage_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

    exe_muldiv_stage #(.XLEN(XLEN), .MUL_LAT(MUL_LAT), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag);
        bus.id_valid_in = 1'b1;
        bus.id_op_in    = op;
        bus.id_src0_in  = a;
        bus.id_src1_in  = b;
        bus.id_tag_in   = tag;
        step();
        bus.id_valid_in = 1'b0;
    endtask

    task automatic wait_valid(input int limit, output int n, output int nb);
        n  = 0;
        nb = 0;
        while (!bus.exe_valid_out && n < limit) begin
            if (!bus.exe_busy_out) nb++;
            step();
            n++;
        end
    endtask

    initial begin
        dv[0] = '{T_DIV,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        dv[1] = '{T_DIV,  32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        dv[2] = '{T_DIVU, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1};
        dv[3] = '{T_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        dv[4] = '{T_DIVU, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0};
        dv[5] = '{T_DIV,  32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1};
        dv[6] = '{T_DIV,  32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0};

        rst_n              = 1'b0;
        bus.flush_in       = 1'b0;
        bus.id_valid_in    = 1'b0;
        bus.mem_allowin_in = 1'b1;
        bus.id_op_in       = T_NONE;
        bus.id_src0_in     = '0;
        bus.id_src1_in     = '0;
        bus.id_tag_in      = '0;
        repeat (3) step();

        check_eq("rst_valid",   32'(bus.exe_valid_out),   32'd0);
        check_eq("rst_busy",    32'(bus.exe_busy_out),    32'd0);
        check_eq("rst_allowin", 32'(bus.exe_allowin_out), 32'd1);
        check_eq("rst_hi",      bus.exe_hi_out,           32'd0);
        check_eq("rst_lo",      bus.exe_lo_out,           32'd0);
        check_eq("rst_tag",     32'(bus.exe_tag_out),     32'd0);
        check_eq("rst_dz",      32'(bus.exe_divzero_out), 32'd0);
        rst_n = 1'b1;
        step();

        // signed multiply -2 * 3
        issue(T_MULT, 32'hFFFFFFFE, 32'd3, 5'd3);
        check_eq("mult_busy0", 32'(bus.exe_busy_out), 32'd1);
        wait_valid(100, cyc, busy_low);
        check_eq("mult_lat",   32'(cyc), 32'd2);
        check_eq("mult_tag",   32'(bus.exe_tag_out), 32'd3);
        check_eq("mult_busyv", 32'(bus.exe_busy_out), 32'd0);
        step();
        check_eq("mult_hi",    bus.exe_hi_out, 32'hFFFFFFFF);
        check_eq("mult_lo",    bus.exe_lo_out, 32'hFFFFFFFA);
        check_eq("mult_vdrop", 32'(bus.exe_valid_out), 32'd0);

        // divide table
        for (int i = 0; i < 7; i++) begin
            issue(dv[i].op, dv[i].a, dv[i].b, 5'(i));
            wait_valid(100, cyc, busy_low);
            check_eq($sformatf("div%0d_lat", i),     32'(cyc),                 32'd33);
            check_eq($sformatf("div%0d_busy", i),    32'(busy_low),            32'd0);
            check_eq($sformatf("div%0d_dz", i),      32'(bus.exe_divzero_out), 32'(dv[i].dz));
            step();
            check_eq($sformatf("div%0d_hi", i),      bus.exe_hi_out,           dv[i].hi);
            check_eq($sformatf("div%0d_lo", i),      bus.exe_lo_out,           dv[i].lo);
            check_eq($sformatf("div%0d_dzclr", i),   32'(bus.exe_divzero_out), 32'd0);
        end

        // unsigned multiply with downstream stall
        bus.mem_allowin_in = 1'b0;
        issue(T_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4);
        wait_valid(100, cyc, busy_low);
        check_eq("multu_lat", 32'(cyc), 32'd2);
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("stall%0d_allowin", i), 32'(bus.exe_allowin_out), 32'd0);
            check_eq($sformatf("stall%0d_valid", i),   32'(bus.exe_valid_out),   32'd1);
            check_eq($sformatf("stall%0d_hi", i),      bus.exe_hi_out,           32'hFFFFFFFF);
            check_eq($sformatf("stall%0d_lo", i),      bus.exe_lo_out,           32'h00000003);
            if (i < 4) step();
        end
        bus.mem_allowin_in = 1'b1;
        #1;
        check_eq("stall_allowin_up", 32'(bus.exe_allowin_out), 32'd1);
        step();
        check_eq("multu_hi", bus.exe_hi_out, 32'hFFFFFFFE);
        check_eq("multu_lo", bus.exe_lo_out, 32'h00000001);

        // flush mid-divide, then MTLO
        issue(T_DIV, 32'd100, 32'd7, 5'd5);
        repeat (9) step();
        bus.flush_in = 1'b1;
        step();
        bus.flush_in = 1'b0;
        check_eq("flush_valid",   32'(bus.exe_valid_out),   32'd0);
        check_eq("flush_busy",    32'(bus.exe_busy_out),    32'd0);
        check_eq("flush_allowin", 32'(bus.exe_allowin_out), 32'd1);
        vcnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.exe_valid_out) vcnt++;
            step();
        end
        check_eq("flush_novalid", 32'(vcnt), 32'd0);
        check_eq("flush_hi", bus.exe_hi_out, 32'hFFFFFFFE);
        check_eq("flush_lo", bus.exe_lo_out, 32'h00000001);
        issue(T_MTLO, 32'h00001234, 32'd0, 5'd6);
        check_eq("mtlo_valid", 32'(bus.exe_valid_out), 32'd1);
        step();
        check_eq("mtlo_lo", bus.exe_lo_out, 32'h00001234);
        check_eq("mtlo_hi", bus.exe_hi_out, 32'hFFFFFFFE);

        // flush wins over a simultaneous capture
        bus.flush_in = 1'b1;
        issue(T_MTHI, 32'h0000DEAD, 32'd0, 5'd7);
        bus.flush_in = 1'b0;
        check_eq("flushcap_valid", 32'(bus.exe_valid_out), 32'd0);
        step();
        check_eq("flushcap_hi", bus.exe_hi_out, 32'hFFFFFFFE);

        issue(T_MTHI, 32'h0000ABCD, 32'd0, 5'd9);
        check_eq("mthi_tag", 32'(bus.exe_tag_out), 32'd9);
        step();
        check_eq("mthi_hi", bus.exe_hi_out, 32'h0000ABCD);
        check_eq("mthi_lo", bus.exe_lo_out, 32'h00001234);

        // reserved op behaves as NONE
        issue(T_RSVD, 32'h55555555, 32'h66666666, 5'h1F);
        check_eq("rsvd_valid", 32'(bus.exe_valid_out), 32'd1);
        check_eq("rsvd_tag",   32'(bus.exe_tag_out),   32'h1F);
        check_eq("rsvd_busy",  32'(bus.exe_busy_out),  32'd0);
        step();
        check_eq("rsvd_hi", bus.exe_hi_out, 32'h0000ABCD);
        check_eq("rsvd_lo", bus.exe_lo_out, 32'h00001234);

        // back-to-back: second op captured on the first op's commit edge
        issue(T_MULT, 32'd7, 32'hFFFFFFFD, 5'd1);
        wait_valid(100, cyc, busy_low);
        check_eq("b2b0_lat", 32'(cyc), 32'd2);
        issue(T_MULTU, 32'd2, 32'd3, 5'd2);
        check_eq("b2b0_hi",   bus.exe_hi_out, 32'hFFFFFFFF);
        check_eq("b2b0_lo",   bus.exe_lo_out, 32'hFFFFFFEB);
        check_eq("b2b1_busy", 32'(bus.exe_busy_out), 32'd1);
        wait_valid(100, cyc, busy_low);
        check_eq("b2b1_lat", 32'(cyc), 32'd2);
        check_eq("b2b1_tag", 32'(bus.exe_tag_out), 32'd2);
        step();
        check_eq("b2b1_hi", bus.exe_hi_out, 32'h00000000);
        check_eq("b2b1_lo", bus.exe_lo_out, 32'h00000006);

        // asynchronous reset in the middle of a divide
        issue(T_DIVU, 32'd1000, 32'd3, 5'd8);
        repeat (5) step();
        rst_n = 1'b0;
        #1;
        check_eq("midrst_hi",      bus.exe_hi_out,           32'd0);
        check_eq("midrst_lo",      bus.exe_lo_out,           32'd0);
        check_eq("midrst_busy",    32'(bus.exe_busy_out),    32'd0);
        check_eq("midrst_allowin", 32'(bus.exe_allowin_out), 32'd1);
        #2;
        rst_n = 1'b1;
        vcnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.exe_valid_out) vcnt++;
            step();
        end
        check_eq("midrst_novalid", 32'(vcnt), 32'd0);
        check_eq("midrst_lo_after", bus.exe_lo_out, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
